// File: rtl/axi_slave_write_control.sv
// AXI4 slave write front end: pushes AW/W into channel FIFOs, returns B from the B FIFO.
// Optional macro AXI_SLV_WLAST_CHECK_EN enables the sticky WLAST-vs-beat-count error flag.
module axi_slave_write_control #(
   parameter int ID_WIDTH          = 10,
   parameter int ADDR_WIDTH        = 64,
   parameter int AxLEN_FIELD_WIDTH = 8,
   parameter int Ax_SIZE_WIDTH     = 3,
   parameter int Ax_BURST_WIDTH    = 2,
   parameter int RESP_WIDTH        = 2,
   parameter int MAX_OUTSTANDING   = 4
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst,
   input  logic [ID_WIDTH-1:0]                    i_m_AWID,
   input  logic [ADDR_WIDTH-1:0]                  i_m_AWADDR,
   input  logic [AxLEN_FIELD_WIDTH-1:0]           i_m_AWLEN,
   input  logic [Ax_SIZE_WIDTH-1:0]               i_m_AWSIZE,
   input  logic [Ax_BURST_WIDTH-1:0]              i_m_AWBURST,
   input  logic                                   i_m_AWVALID,
   output logic                                   o_m_AWREADY,
   input  logic                                   i_m_WVALID,
   input  logic                                   i_m_WLAST,
   output logic                                   o_m_WREADY,
   output logic [ID_WIDTH-1:0]                    o_m_BID,
   output logic [RESP_WIDTH-1:0]                  o_m_BRESP,
   output logic                                   o_m_BVALID,
   input  logic                                   i_m_BREADY,
   output logic                                   o_aw_ch_fifo_write_inc,
   output logic [ID_WIDTH+ADDR_WIDTH+AxLEN_FIELD_WIDTH+Ax_SIZE_WIDTH+Ax_BURST_WIDTH-1:0] o_AW_CHANNEL,
   input  logic                                   i_aw_ch_fifo_full,
   output logic                                   o_w_ch_fifo_write_inc,
   input  logic                                   i_w_ch_fifo_full,
   input  logic                                   i_b_ch_fifo_empty,
   input  logic [ID_WIDTH+RESP_WIDTH-1:0]         i_B_CHANNEL,
   output logic                                   o_b_ch_fifo_read_inc,
   output logic                                   o_wlast_err
);

   localparam int OUTST_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OUTST_W-1:0] MAX_OUT = OUTST_W'(MAX_OUTSTANDING);

   typedef enum logic {W_IDLE, W_DATA} w_state_t;

   w_state_t                       state;
   logic [AxLEN_FIELD_WIDTH-1:0]   beat_cnt;
   logic [OUTST_W-1:0]             outst;
   logic                           aw_hs;
   logic                           w_acc;
   logic                           b_hs;
   logic                           b_load;

   assign o_m_AWREADY = ~i_rst & (state == W_IDLE) & ~i_aw_ch_fifo_full & (outst < MAX_OUT);
   assign o_m_WREADY  = ~i_rst & (state == W_DATA) & ~i_w_ch_fifo_full;

   assign aw_hs  = o_m_AWREADY & i_m_AWVALID;
   assign w_acc  = o_m_WREADY & i_m_WVALID;
   assign b_hs   = ~i_rst & o_m_BVALID & i_m_BREADY;
   assign b_load = ~i_rst & (~o_m_BVALID | i_m_BREADY) & ~i_b_ch_fifo_empty;

   assign o_aw_ch_fifo_write_inc = aw_hs;
   assign o_w_ch_fifo_write_inc  = w_acc;
   assign o_b_ch_fifo_read_inc   = b_load;
   assign o_AW_CHANNEL = {i_m_AWID, i_m_AWADDR, i_m_AWLEN, i_m_AWSIZE, i_m_AWBURST};

   // W FSM: beat_cnt holds beats remaining minus one for the burst in flight
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= W_IDLE;
         beat_cnt <= '0;
      end else begin
         case (state)
            W_IDLE: begin
               if (aw_hs) begin
                  beat_cnt <= i_m_AWLEN;
                  state    <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_acc) begin
                  if (beat_cnt == '0) state <= W_IDLE;
                  else                beat_cnt <= beat_cnt - 1'b1;
               end
            end
            default: state <= W_IDLE;
         endcase
      end
   end

   // Outstanding count; a B delivered with nothing outstanding leaves it at zero
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         outst <= '0;
      end else if (aw_hs && !b_hs) begin
         outst <= outst + 1'b1;
      end else if (b_hs && !aw_hs && (outst != '0)) begin
         outst <= outst - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_m_BVALID <= 1'b0;
         o_m_BID    <= '0;
         o_m_BRESP  <= '0;
      end else if (b_load) begin
         o_m_BVALID <= 1'b1;
         {o_m_BID, o_m_BRESP} <= i_B_CHANNEL;
      end else if (i_m_BREADY) begin
         o_m_BVALID <= 1'b0;
      end
   end

`ifdef AXI_SLV_WLAST_CHECK_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_wlast_err <= 1'b0;
      end else if (w_acc && (i_m_WLAST != (beat_cnt == '0))) begin
         o_wlast_err <= 1'b1;
      end
   end
`else
   wire unused_wlast = i_m_WLAST;
   assign o_wlast_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_slave_write_control.sv
// Bench for axi_slave_write_control: directed scenarios then random traffic against a burst-level model.
module tb_axi_slave_write_control;
   localparam int MAXO = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [9:0]  awid;
   logic [63:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid, wvalid, wlast, bready, aw_full, w_full, b_empty;
   logic [11:0] b_chan;
   logic        awready, wready, bvalid, aw_inc, w_inc, b_inc, wlast_err;
   logic [9:0]  bid;
   logic [1:0]  bresp;
   logic [86:0] aw_chan;

   axi_slave_write_control #(.MAX_OUTSTANDING(MAXO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_m_AWID(awid), .i_m_AWADDR(awaddr), .i_m_AWLEN(awlen), .i_m_AWSIZE(awsize),
      .i_m_AWBURST(awburst), .i_m_AWVALID(awvalid), .o_m_AWREADY(awready),
      .i_m_WVALID(wvalid), .i_m_WLAST(wlast), .o_m_WREADY(wready),
      .o_m_BID(bid), .o_m_BRESP(bresp), .o_m_BVALID(bvalid), .i_m_BREADY(bready),
      .o_aw_ch_fifo_write_inc(aw_inc), .o_AW_CHANNEL(aw_chan), .i_aw_ch_fifo_full(aw_full),
      .o_w_ch_fifo_write_inc(w_inc), .i_w_ch_fifo_full(w_full),
      .i_b_ch_fifo_empty(b_empty), .i_B_CHANNEL(b_chan), .o_b_ch_fifo_read_inc(b_inc),
      .o_wlast_err(wlast_err)
   );

   int vectors = 0;
   int miscompares = 0;

   // Burst-level reference: whether a burst owns W, beats still owed, writes awaiting B, B register
   bit          m_busy = 1'b0;
   int          m_left = 0;
   int          m_outst = 0;
   bit          m_bvalid = 1'b0;
   logic [11:0] m_b = '0;
   bit          m_err = 1'b0;
   logic [11:0] bq[$];
   logic [9:0]  bseen[$];
   int          w_pushes = 0, aw_pushes = 0, b_pops = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      b_empty = (bq.size() == 0);
      b_chan  = b_empty ? 12'h000 : bq[0];
   endtask

   task automatic cycle();
      bit e_awr, e_wr, e_awinc, e_winc, e_binc, hs_b;
      e_awr   = !rst && !m_busy && !aw_full && (m_outst < MAXO);
      e_wr    = !rst && m_busy && !w_full;
      e_awinc = e_awr && awvalid;
      e_winc  = e_wr && wvalid;
      e_binc  = !rst && (!m_bvalid || bready) && (bq.size() != 0);
      @(negedge clk);
      chk("awready", 128'(awready), 128'(e_awr));
      chk("wready", 128'(wready), 128'(e_wr));
      chk("aw_inc", 128'(aw_inc), 128'(e_awinc));
      chk("w_inc", 128'(w_inc), 128'(e_winc));
      chk("b_inc", 128'(b_inc), 128'(e_binc));
      chk("bvalid", 128'(bvalid), 128'(m_bvalid));
      chk("bid_bresp", 128'({bid, bresp}), 128'(m_b));
      chk("wlast_err", 128'(wlast_err), 128'(m_err));
      if (e_awinc) chk("aw_channel", 128'(aw_chan), 128'({awid, awaddr, awlen, awsize, awburst}));
      if (w_inc) w_pushes++;
      if (aw_inc) aw_pushes++;
      if (b_inc) b_pops++;
      if (bvalid && bready) bseen.push_back(bid);
      @(posedge clk);
      if (rst) begin
         m_busy = 0; m_left = 0; m_outst = 0; m_bvalid = 0; m_b = '0; m_err = 0;
      end else begin
         hs_b = m_bvalid && bready;
         if (e_awinc) begin
            m_busy = 1; m_left = int'(awlen) + 1;
         end else if (e_winc) begin
`ifdef AXI_SLV_WLAST_CHECK_EN
            if (wlast != (m_left == 1)) m_err = 1;
`endif
            m_left--;
            if (m_left == 0) m_busy = 0;
         end
         if (e_awinc && !hs_b) m_outst++;
         else if (hs_b && !e_awinc && m_outst > 0) m_outst--;
         if (e_binc) begin
            m_bvalid = 1; m_b = bq.pop_front();
         end else if (bready) m_bvalid = 0;
      end
      #1;
      refresh();
   endtask

   task automatic send_aw(input logic [9:0] id, input logic [7:0] len);
      awid = id; awaddr = {$urandom, $urandom}; awlen = len;
      awsize = 3'($urandom); awburst = 2'($urandom); awvalid = 1'b1;
      cycle();
      awvalid = 1'b0;
   endtask

   task automatic drain_b(input int n);
      bready = 1'b1;
      for (int i = 0; i < n; i++) bq.push_back({10'($urandom), 2'($urandom)});
      refresh();
      for (int i = 0; i < n + 2; i++) cycle();
   endtask

   initial begin
      rst = 1'b1; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
      awvalid = 1'b1; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0; aw_full = 1'b0; w_full = 1'b0;
      refresh();
      @(posedge clk); @(posedge clk); #1;
      cycle();

      // Basic AWLEN=3 burst
      rst = 1'b0; awvalid = 1'b0;
      w_pushes = 0; aw_pushes = 0;
      send_aw(10'h012, 8'd3);
      wvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wlast = (i == 3);
         cycle();
      end
      wvalid = 1'b0; wlast = 1'b0;
      cycle();
      chk("burst1_wpushes", 128'(w_pushes), 128'(4));
      chk("burst1_awpushes", 128'(aw_pushes), 128'(1));
      drain_b(1);

      // W FIFO full for two cycles after beat 2
      w_pushes = 0;
      send_aw(10'h012, 8'd3);
      wvalid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         w_full = (i == 2 || i == 3);
         wlast  = (i == 5);
         cycle();
      end
      w_full = 1'b0; wvalid = 1'b0; wlast = 1'b0;
      cycle();
      chk("stall_wpushes", 128'(w_pushes), 128'(4));
      drain_b(1);

      // Outstanding limit of two
      aw_pushes = 0; bready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         send_aw(10'(k), 8'd0);
         wvalid = 1'b1; wlast = 1'b1; cycle();
         wvalid = 1'b0; wlast = 1'b0;
      end
      awid = 10'h003; awvalid = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      chk("limit_blocked", 128'(aw_pushes), 128'(2));
      bq.push_back({10'h000, 2'b00}); refresh();
      cycle();
      bready = 1'b1;
      cycle();
      cycle();
      chk("limit_released", 128'(aw_pushes), 128'(3));
      awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b1; cycle();
      wvalid = 1'b0; wlast = 1'b0;
      drain_b(2);

      // Back-to-back B, then hold under BREADY=0
      bseen.delete();
      bready = 1'b1;
      bq.push_back({10'h005, 2'b01}); bq.push_back({10'h006, 2'b10}); refresh();
      for (int i = 0; i < 4; i++) cycle();
      chk("b_count", 128'(bseen.size()), 128'(2));
      if (bseen.size() == 2) begin
         chk("b_first", 128'(bseen[0]), 128'(10'h005));
         chk("b_second", 128'(bseen[1]), 128'(10'h006));
      end
      bready = 1'b0; b_pops = 0;
      bq.push_back({10'h007, 2'b00}); bq.push_back({10'h008, 2'b11}); refresh();
      for (int i = 0; i < 4; i++) cycle();
      chk("b_hold_pops", 128'(b_pops), 128'(1));
      chk("b_hold_id", 128'(bid), 128'(10'h007));
      bready = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      // Early WLAST on a two-beat burst
      w_pushes = 0;
      send_aw(10'h0AA, 8'd1);
      wvalid = 1'b1; wlast = 1'b1; cycle();
      wlast = 1'b0; cycle();
      wvalid = 1'b0;
      cycle();
      chk("wlast_pushes", 128'(w_pushes), 128'(2));
`ifdef AXI_SLV_WLAST_CHECK_EN
      chk("wlast_flag", 128'(wlast_err), 128'(1));
`else
      chk("wlast_flag", 128'(wlast_err), 128'(0));
`endif

      // Reset during beat 3 of an eight-beat burst with a B pending
      bready = 1'b0;
      bq.push_back({10'h1FF, 2'b11}); refresh();
      send_aw(10'h0BB, 8'd7);
      wvalid = 1'b1;
      cycle(); cycle();
      rst = 1'b1; cycle();
      rst = 1'b0; wvalid = 1'b0; awvalid = 1'b1;
      cycle();
      chk("post_reset_bvalid", 128'(bvalid), 128'(0));
      awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      wvalid = 1'b0;
      drain_b(2);

      // Random traffic
      for (int n = 0; n < 800; n++) begin
         rst     = ($urandom_range(0, 149) == 0);
         awvalid = 1'($urandom);
         awid    = 10'($urandom);
         awaddr  = {$urandom, $urandom};
         awlen   = 8'($urandom_range(0, 3));
         awsize  = 3'($urandom);
         awburst = 2'($urandom);
         wvalid  = 1'($urandom);
         wlast   = 1'($urandom);
         bready  = ($urandom_range(0, 3) != 0);
         aw_full = ($urandom_range(0, 3) == 0);
         w_full  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) == 0 && bq.size() < 4) bq.push_back(12'($urandom));
         refresh();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
